sync_tp_ram: RTL

Single-clock two-port RAM with byte-lane write enables, a configurable valid-tagged read pipeline, and a selectable read-during-write collision mode. It is the parametrised successor to `tp_ram` for same-clock-domain buffers, such as synchronous FIFOs and packet staging, where `rd_valid` tracking and defined collision behaviour are needed. An optional post-reset clear sweep zeroes the array.

---
 rtl/tp_ram_pkg.sv | 20 ++
 rtl/tp_ram_out_pipe.sv | 43 ++++
 rtl/sync_tp_ram.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/tp_ram_pkg.sv
// Shared constants, address-width helper and clear-sweep state type for sync_tp_ram.
package tp_ram_pkg;

    localparam string RDW_WRITE_FIRST = "write_first";
    localparam string RDW_READ_FIRST  = "read_first";

    typedef enum logic [0:0] {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } sweep_state_e;

    function automatic int addr_width(input int depth);
        if (depth <= 2) begin
            return 1;
        end else begin
            return $clog2(depth);
        end
    endfunction

endpackage

// File: rtl/tp_ram_out_pipe.sv
// Valid-tagged read pipeline: stage 0 capture, OUTPUT_REG middle stages, registered output.
module tp_ram_out_pipe #(
    parameter int DATA_WIDTH = 8,
    parameter int OUTPUT_REG = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic                  o_valid,
    output logic [DATA_WIDTH-1:0] o_data
);

    localparam int LAST = OUTPUT_REG + 1;

    logic                  r_vld [0:LAST];
    logic [DATA_WIDTH-1:0] r_dat [0:LAST];

    // Each stage only reloads data behind a valid bit, so the output holds the last read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i <= LAST; i++) begin
                r_vld[i] <= 1'b0;
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= i_valid;
            if (i_valid) begin
                r_dat[0] <= i_data;
            end
            for (int i = 1; i <= LAST; i++) begin
                r_vld[i] <= r_vld[i-1];
                if (r_vld[i-1]) begin
                    r_dat[i] <= r_dat[i-1];
                end
            end
        end
    end

    assign o_valid = r_vld[LAST];
    assign o_data  = r_dat[LAST];

endmodule

// File: rtl/sync_tp_ram.sv
// Single-clock two-port RAM with byte-lane writes, valid-tagged read pipeline and RDW mode.
// Define SYNC_TP_RAM_INIT_CLEAR_EN to compile in the post-reset clear sweep.
module sync_tp_ram
    import tp_ram_pkg::*;
#(
    parameter int    DEPTH      = 16,
    parameter int    DATA_WIDTH = 8,
    parameter int    LANE_WIDTH = 8,
    parameter int    OUTPUT_REG = 2,
    parameter string RAM_TYPE   = "register",
    parameter string RDW_MODE   = RDW_WRITE_FIRST,
    localparam int   ADDR_WIDTH = addr_width(DEPTH),
    localparam int   NUM_LANES  = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [NUM_LANES-1:0]  wr_be,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  rd_valid,
    output logic                  init_busy
);

    localparam bit                WRITE_FIRST = (RDW_MODE != RDW_READ_FIRST);
    localparam logic [ADDR_WIDTH:0] DEPTH_W   = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [0:DEPTH-1];

    logic                  w_busy;
    logic [ADDR_WIDTH-1:0] w_clr_addr;
    logic                  w_wr_in;
    logic                  w_rd_in;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_coll;
    logic [DATA_WIDTH-1:0] w_lane_mask;
    logic                  w_we;
    logic [ADDR_WIDTH-1:0] w_waddr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_wmask;
    logic [DATA_WIDTH-1:0] w_rd_word;

`ifdef SYNC_TP_RAM_INIT_CLEAR_EN
    localparam int                  LAST_I    = DEPTH - 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = LAST_I[ADDR_WIDTH-1:0];

    sweep_state_e          r_state;
    logic [ADDR_WIDTH-1:0] r_clr_cnt;

    // Clear sweep: one word per cycle from 0 to DEPTH-1, restarted by every reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_CLEAR;
            r_clr_cnt <= '0;
        end else begin
            case (r_state)
                ST_CLEAR: begin
                    if (r_clr_cnt == LAST_ADDR) begin
                        r_state <= ST_READY;
                    end else begin
                        r_clr_cnt <= r_clr_cnt + ADDR_WIDTH'(1);
                    end
                end
                ST_READY: r_state <= ST_READY;
                default:  r_state <= ST_CLEAR;
            endcase
        end
    end

    assign w_busy     = (r_state == ST_CLEAR);
    assign w_clr_addr = r_clr_cnt;
`else
    assign w_busy     = 1'b0;
    assign w_clr_addr = '0;
`endif

    assign w_wr_in = ({1'b0, wr_addr} < DEPTH_W);
    assign w_rd_in = ({1'b0, rd_addr} < DEPTH_W);
    assign w_wr_ok = wr_en & ~w_busy & w_wr_in;
    assign w_rd_ok = rd_en & ~w_busy;
    assign w_coll  = w_rd_ok & w_wr_ok & (rd_addr == wr_addr);

    // Expand lane enables to a bit mask.
    always_comb begin
        w_lane_mask = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            w_lane_mask[k*LANE_WIDTH +: LANE_WIDTH] = {LANE_WIDTH{wr_be[k]}};
        end
    end

    // Array write port is owned by the sweep while it runs, by the user otherwise.
    always_comb begin
        if (w_busy) begin
            w_we    = 1'b1;
            w_waddr = w_clr_addr;
            w_wdata = '0;
            w_wmask = '1;
        end else begin
            w_we    = w_wr_ok;
            w_waddr = wr_addr;
            w_wdata = wr_data;
            w_wmask = w_lane_mask;
        end
    end

    // Read word with out-of-range zeroing and write-first lane merge on collision.
    always_comb begin
        w_rd_word = '0;
        if (w_rd_in) begin
            if (WRITE_FIRST && w_coll) begin
                w_rd_word = (r_mem[rd_addr] & ~w_lane_mask) | (wr_data & w_lane_mask);
            end else begin
                w_rd_word = r_mem[rd_addr];
            end
        end else begin
            w_rd_word = '0;
        end
    end

    if (RAM_TYPE == "block") begin : g_block
        // Block array: no reset so it can map onto RAM primitives.
        always_ff @(posedge clk) begin
            if (w_we) begin
                r_mem[w_waddr] <= (r_mem[w_waddr] & ~w_wmask) | (w_wdata & w_wmask);
            end
        end
    end else begin : g_register
        // Flop array, cleared by reset.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                for (int i = 0; i < DEPTH; i++) begin
                    r_mem[i] <= '0;
                end
            end else if (w_we) begin
                r_mem[w_waddr] <= (r_mem[w_waddr] & ~w_wmask) | (w_wdata & w_wmask);
            end
        end
    end

    tp_ram_out_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .OUTPUT_REG (OUTPUT_REG)
    ) u_out_pipe (
        .clk     (clk),
        .rst     (rst),
        .i_valid (w_rd_ok),
        .i_data  (w_rd_word),
        .o_valid (rd_valid),
        .o_data  (rd_data)
    );

    assign init_busy = w_busy;

endmodule
